imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 171 +++++++++++++++++
 tb/tb_imm_decode_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage for a LEGv8 datapath.
// Holds one fetched instruction in a valid/ready skid-free register, decodes
// which immediate format the SignExtend unit must extract (one-hot imm_op),
// and keeps a saturating count of delivered instructions that carry an
// immediate. A flush (branch redirect) drops both the held and the incoming
// instruction.

`ifndef INSTSIZE
`define INSTSIZE 32
`endif

module imm_decode_stage (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [`INSTSIZE-1:0] in_inst,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [`INSTSIZE-1:0] out_inst,
  output logic [4:0]           imm_op,
  output logic [15:0]          imm_count
);

  // One-hot immediate selects for the SignExtend unit.
  localparam logic [4:0] IMM_NONE  = 5'b00000;
  localparam logic [4:0] IMM_D     = 5'b00001;
  localparam logic [4:0] IMM_SHIFT = 5'b00010;
  localparam logic [4:0] IMM_I     = 5'b00100;
  localparam logic [4:0] IMM_CB    = 5'b01000;
  localparam logic [4:0] IMM_B     = 5'b10000;

  // B-format opcodes, inst[31:26]: B, BL.
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;
  // CB-format opcodes, inst[31:24]: CBZ, CBNZ, B.cond.
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [7:0]  OPC_BCND = 8'b01010100;
  // D-format opcodes, inst[31:21]: LDUR, STUR.
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // Shift opcodes, inst[31:21]: LSL, LSR.
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  // I-format opcodes, inst[31:22]: ADDI, ADDIS, SUBI, SUBIS, ANDI, ORRI, EORI.
  localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OPC_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OPC_SUBIS = 10'b1111000100;
  localparam logic [9:0]  OPC_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OPC_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OPC_EORI  = 10'b1101001000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic [`INSTSIZE-1:0]   r_inst;
  logic [4:0]             r_imm_op;
  logic [15:0]            r_imm_count;
  logic [4:0]             w_decoded;
  logic                   w_accept;
  logic                   w_deliver_imm;

  // Priority decode: branch formats win over memory, shift and arithmetic
  // formats so overlapping opcode prefixes can never light two select bits.
  function automatic logic [4:0] decode_imm(input logic [31:0] inst);
    logic [4:0] op;
    op = IMM_NONE;
    if (inst[31:26] inside {OPC_B, OPC_BL}) begin
      op = IMM_B;
    end else if (inst[31:24] inside {OPC_CBZ, OPC_CBNZ, OPC_BCND}) begin
      op = IMM_CB;
    end else if (inst[31:21] inside {OPC_LDUR, OPC_STUR}) begin
      op = IMM_D;
    end else if (inst[31:21] inside {OPC_LSL, OPC_LSR}) begin
      op = IMM_SHIFT;
    end else if (inst[31:22] inside {OPC_ADDI, OPC_ADDIS, OPC_SUBI, OPC_SUBIS,
                                     OPC_ANDI, OPC_ORRI, OPC_EORI}) begin
      op = IMM_I;
    end
    return op;
  endfunction

  assign w_decoded = decode_imm(in_inst[31:0]);

  // A transfer in is blocked by flush even though in_ready stays honest.
  assign w_accept = in_valid & in_ready & ~flush;

  // Only deliveries of instructions with an immediate bump the counter.
  assign w_deliver_imm = out_valid & out_ready & (imm_op != IMM_NONE) & ~flush;

  // State register: occupancy of the single output slot.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: flush dominates, then a new accept fills the slot,
  // otherwise a completed delivery drains it.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is
    // inferred when none of the branches below fire.
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else if (w_accept) begin
      w_next_state = ST_FULL;
    end else if (r_state == ST_FULL && out_ready) begin
      w_next_state = ST_EMPTY;
    end
  end

  // Output logic: handshake signals and the gated immediate select.
  always_comb begin
    out_valid = 1'b0;
    imm_op    = IMM_NONE;
    in_ready  = 1'b0;
    if (r_state == ST_FULL) begin
      out_valid = 1'b1;
      imm_op    = r_imm_op;
    end
    // Upstream may fill an empty slot or refill one being drained this cycle;
    // reset holds it off so nothing is accepted until rst falls.
    in_ready = ~rst & ((r_state == ST_EMPTY) | out_ready);
  end

  // Payload register: captures instruction and its decoded select on accept,
  // otherwise holds so a stalled consumer sees a stable word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst   <= '0;
      r_imm_op <= IMM_NONE;
    end else if (w_accept) begin
      r_inst   <= in_inst;
      r_imm_op <= w_decoded;
    end
  end

  // Delivery counter: saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imm_count <= '0;
    end else if (w_deliver_imm && r_imm_count != 16'hFFFF) begin
      r_imm_count <= r_imm_count + 16'd1;
    end
  end

  assign out_inst  = r_inst;
  assign imm_count = r_imm_count;

`ifndef SYNTHESIS
  // The select driven to SignExtend is never multi-hot.
  a_imm_onehot0: assert property (@(posedge clk) $onehot0(imm_op));

  // A stalled, unflushed output stays put until it is taken.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_inst) && $stable(imm_op)));
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage: reset, per-format decode,
// back-to-back streaming, stall hold, flush, counter saturation and
// reset during a held instruction.

`timescale 1ns/1ps

module tb_imm_decode_stage;

  localparam logic [31:0] INST_B     = 32'h14000001;
  localparam logic [31:0] INST_ADDI  = 32'h91000421;
  localparam logic [31:0] INST_LDUR  = 32'hF8400020;
  localparam logic [31:0] INST_LSL   = 32'hD37FF800;
  localparam logic [31:0] INST_CBZ   = 32'hB4000040;
  localparam logic [31:0] INST_ADD   = 32'h8B020020;
  localparam logic [31:0] INST_BCOND = 32'h54000001;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [4:0]  imm_op;
  logic [15:0] imm_count;

  int checks = 0;
  int errors = 0;

  imm_decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .imm_op    (imm_op),
    .imm_count (imm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (imm_op !== 5'b00000) begin errors++; $display("FAIL rst_imm_op got %b want 00000", imm_op); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst got %h want 00000000", out_inst); end
    checks++; if (imm_count !== 16'h0) begin errors++; $display("FAIL rst_imm_count got %h want 0000", imm_count); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_b_branch();
    in_valid = 1'b1; in_inst = INST_B; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b_out_valid got %b want 1", out_valid); end
    checks++; if (imm_op !== 5'b10000) begin errors++; $display("FAIL b_imm_op got %b want 10000", imm_op); end
    checks++; if (out_inst !== INST_B) begin errors++; $display("FAIL b_out_inst got %h want %h", out_inst, INST_B); end
    checks++; if (imm_count !== 16'd0) begin errors++; $display("FAIL b_count_before got %0d want 0", imm_count); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b_drained got %b want 0", out_valid); end
    checks++; if (imm_count !== 16'd1) begin errors++; $display("FAIL b_count_after got %0d want 1", imm_count); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_inst = INST_ADDI; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready0 got %b want 1", in_ready); end
    step();
    checks++; if (imm_op !== 5'b00100) begin errors++; $display("FAIL b2b_addi_imm_op got %b want 00100", imm_op); end
    checks++; if (out_inst !== INST_ADDI) begin errors++; $display("FAIL b2b_addi_inst got %h want %h", out_inst, INST_ADDI); end
    in_inst = INST_LDUR;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready1 got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_ldur_valid got %b want 1", out_valid); end
    checks++; if (imm_op !== 5'b00001) begin errors++; $display("FAIL b2b_ldur_imm_op got %b want 00001", imm_op); end
    checks++; if (imm_count !== 16'd2) begin errors++; $display("FAIL b2b_count2 got %0d want 2", imm_count); end
    in_inst = INST_LSL;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready2 got %b want 1", in_ready); end
    step();
    checks++; if (imm_op !== 5'b00010) begin errors++; $display("FAIL b2b_lsl_imm_op got %b want 00010", imm_op); end
    checks++; if (out_inst !== INST_LSL) begin errors++; $display("FAIL b2b_lsl_inst got %h want %h", out_inst, INST_LSL); end
    checks++; if (imm_count !== 16'd3) begin errors++; $display("FAIL b2b_count3 got %0d want 3", imm_count); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", out_valid); end
    checks++; if (imm_count !== 16'd4) begin errors++; $display("FAIL b2b_count4 got %0d want 4", imm_count); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_inst = INST_CBZ; out_ready = 1'b0;
    step();
    in_inst = INST_ADD;  // still valid upstream, must not be taken while stalled
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_inst !== INST_CBZ) begin errors++; $display("FAIL stall_inst[%0d] got %h want %h", i, out_inst, INST_CBZ); end
      checks++; if (imm_op !== 5'b01000) begin errors++; $display("FAIL stall_imm_op[%0d] got %b want 01000", i, imm_op); end
      step();
    end
    checks++; if (imm_count !== 16'd4) begin errors++; $display("FAIL stall_count_held got %0d want 4", imm_count); end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %b want 0", out_valid); end
    checks++; if (imm_count !== 16'd5) begin errors++; $display("FAIL stall_count got %0d want 5", imm_count); end
    step();
    checks++; if (imm_count !== 16'd5) begin errors++; $display("FAIL stall_once got %0d want 5", imm_count); end
  endtask

  task automatic test_rformat();
    in_valid = 1'b1; in_inst = INST_ADD; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", out_valid); end
    checks++; if (imm_op !== 5'b00000) begin errors++; $display("FAIL add_imm_op got %b want 00000", imm_op); end
    checks++; if (out_inst !== INST_ADD) begin errors++; $display("FAIL add_inst got %h want %h", out_inst, INST_ADD); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b want 0", out_valid); end
    checks++; if (imm_count !== 16'd5) begin errors++; $display("FAIL add_count got %0d want 5", imm_count); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_inst = INST_BCOND; out_ready = 1'b0;
    step();
    checks++; if (imm_op !== 5'b01000) begin errors++; $display("FAIL flush_bcond_imm_op got %b want 01000", imm_op); end
    flush = 1'b1; in_valid = 1'b1; in_inst = INST_B; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (imm_count !== 16'd5) begin errors++; $display("FAIL flush_count got %0d want 5", imm_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_later got %b want 0", out_valid); end
    checks++; if (imm_count !== 16'd5) begin errors++; $display("FAIL flush_count_later got %0d want 5", imm_count); end
  endtask

  task automatic test_saturate();
    force dut.r_imm_count = 16'hFFFD;
    #1;
    release dut.r_imm_count;
    checks++; if (imm_count !== 16'hFFFD) begin errors++; $display("FAIL sat_preload got %h want FFFD", imm_count); end
    in_valid = 1'b1; in_inst = INST_B; out_ready = 1'b1;
    step();
    checks++; if (imm_count !== 16'hFFFD) begin errors++; $display("FAIL sat_accept got %h want FFFD", imm_count); end
    step();
    checks++; if (imm_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %h want FFFE", imm_count); end
    step();
    checks++; if (imm_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %h want FFFF", imm_count); end
    in_valid = 1'b0;
    step();
    checks++; if (imm_count !== 16'hFFFF) begin errors++; $display("FAIL sat_nowrap got %h want FFFF", imm_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drained got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_hold();
    in_valid = 1'b1; in_inst = INST_CBZ; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_held got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    checks++; if (imm_op !== 5'b00000) begin errors++; $display("FAIL rmid_imm_op got %b want 00000", imm_op); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready got %b want 0", in_ready); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rmid_inst got %h want 00000000", out_inst); end
    checks++; if (imm_count !== 16'h0) begin errors++; $display("FAIL rmid_count got %h want 0000", imm_count); end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_valid got %b want 0", out_valid); end
    in_valid = 1'b1; in_inst = INST_ADDI;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_first_accept got %b want 1", out_valid); end
    checks++; if (imm_op !== 5'b00100) begin errors++; $display("FAIL rmid_first_imm_op got %b want 00100", imm_op); end
    checks++; if (imm_count !== 16'd0) begin errors++; $display("FAIL rmid_count0 got %0d want 0", imm_count); end
    in_valid = 1'b0;
    step();
    checks++; if (imm_count !== 16'd1) begin errors++; $display("FAIL rmid_count1 got %0d want 1", imm_count); end
  endtask

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_b_branch();
    test_back_to_back();
    test_stall();
    test_rformat();
    test_flush();
    test_saturate();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
